// File: rtl/mux_sel_pipe.sv
// N-way WIDTH-bit select mux with a registered valid/ready output stage.
// A two-entry skid buffer (main + skid) keeps full throughput while in_ready stays registered.
module mux_sel_pipe #(
    parameter int WIDTH  = 5,
    parameter int NUM_IN = 2,
    localparam int SEL_W = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        in_sel,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_sel,
    output logic                    err_sel,
    input  logic                    clr_err
);

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;

    // Out-of-range selects match no input and therefore yield all-zero.
    function automatic logic [WIDTH-1:0] sel_word(input logic [NUM_IN*WIDTH-1:0] d,
                                                  input logic [SEL_W-1:0]        s);
        logic [WIDTH-1:0] w;
        w = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if ({1'b0, s} == (SEL_W+1)'(k))
                w = d[k*WIDTH +: WIDTH];
        end
        return w;
    endfunction

    function automatic logic sel_in_range(input logic [SEL_W-1:0] s);
        return ({1'b0, s} < (SEL_W+1)'(NUM_IN));
    endfunction

    logic [1:0]       state_p1;
    logic [1:0]       state_nxt;
    logic             rdy_p1;
    logic [WIDTH-1:0] main_data_p1;
    logic [SEL_W-1:0] main_sel_p1;
    logic [WIDTH-1:0] skid_data_p1;
    logic [SEL_W-1:0] skid_sel_p1;
    logic             err_p1;

    logic             push;
    logic             pop;
    logic             ld_main_in;
    logic             ld_main_skid;
    logic             ld_skid;
    logic [WIDTH-1:0] word_p0;

    assign in_ready  = rdy_p1;
    assign out_valid = (state_p1 != EMPTY);
    assign out_data  = main_data_p1;
    assign out_sel   = main_sel_p1;
    assign err_sel   = err_p1;

    assign push    = in_valid & rdy_p1;
    assign pop     = out_valid & out_ready;
    assign word_p0 = sel_word(in_data, in_sel);

    always_comb begin
        state_nxt    = state_p1;
        ld_main_in   = 1'b0;
        ld_main_skid = 1'b0;
        ld_skid      = 1'b0;
        case (state_p1)
            EMPTY: begin
                if (push) begin
                    state_nxt  = ONE;
                    ld_main_in = 1'b1;
                end
            end
            ONE: begin
                if (push && pop) begin
                    ld_main_in = 1'b1;
                end else if (push) begin
                    state_nxt = FULL;
                    ld_skid   = 1'b1;
                end else if (pop) begin
                    state_nxt = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    state_nxt    = ONE;
                    ld_main_skid = 1'b1;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    // Stage p1: buffer state, ready flag and payload registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_p1     <= EMPTY;
            rdy_p1       <= 1'b0;
            main_data_p1 <= '0;
            main_sel_p1  <= '0;
            skid_data_p1 <= '0;
            skid_sel_p1  <= '0;
            err_p1       <= 1'b0;
        end else begin
            state_p1 <= state_nxt;
            rdy_p1   <= (state_nxt != FULL);
            if (ld_main_in) begin
                main_data_p1 <= word_p0;
                main_sel_p1  <= in_sel;
            end else if (ld_main_skid) begin
                main_data_p1 <= skid_data_p1;
                main_sel_p1  <= skid_sel_p1;
            end
            if (ld_skid) begin
                skid_data_p1 <= word_p0;
                skid_sel_p1  <= in_sel;
            end
            // A fresh out-of-range push beats a simultaneous clear.
            if (push && !sel_in_range(in_sel))
                err_p1 <= 1'b1;
            else if (clr_err)
                err_p1 <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_sel_pipe.sv
// Directed and randomised bench for mux_sel_pipe across several parameter sets.
module tb_mux_sel_pipe;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int nvec = 0;
    int nmis = 0;

    // A: WIDTH=5 NUM_IN=2
    logic a_iv = 0, a_ir, a_ov, a_or = 0, a_es, a_ce = 0;
    logic [9:0] a_id = '0;
    logic [0:0] a_is = '0, a_os;
    logic [4:0] a_od;
    // B: WIDTH=5 NUM_IN=4
    logic b_iv = 0, b_ir, b_ov, b_or = 0, b_es, b_ce = 0;
    logic [19:0] b_id = '0;
    logic [1:0] b_is = '0, b_os;
    logic [4:0] b_od;
    // C: WIDTH=5 NUM_IN=3
    logic c_iv = 0, c_ir, c_ov, c_or = 0, c_es, c_ce = 0;
    logic [14:0] c_id = '0;
    logic [1:0] c_is = '0, c_os;
    logic [4:0] c_od;
    // D: WIDTH=8 NUM_IN=5
    logic d_iv = 0, d_ir, d_ov, d_or = 0, d_es, d_ce = 0;
    logic [39:0] d_id = '0;
    logic [2:0] d_is = '0, d_os;
    logic [7:0] d_od;

    mux_sel_pipe #(.WIDTH(5), .NUM_IN(2)) u_a (
        .clk(clk), .rst(rst), .in_valid(a_iv), .in_ready(a_ir), .in_data(a_id), .in_sel(a_is),
        .out_valid(a_ov), .out_ready(a_or), .out_data(a_od), .out_sel(a_os), .err_sel(a_es), .clr_err(a_ce));
    mux_sel_pipe #(.WIDTH(5), .NUM_IN(4)) u_b (
        .clk(clk), .rst(rst), .in_valid(b_iv), .in_ready(b_ir), .in_data(b_id), .in_sel(b_is),
        .out_valid(b_ov), .out_ready(b_or), .out_data(b_od), .out_sel(b_os), .err_sel(b_es), .clr_err(b_ce));
    mux_sel_pipe #(.WIDTH(5), .NUM_IN(3)) u_c (
        .clk(clk), .rst(rst), .in_valid(c_iv), .in_ready(c_ir), .in_data(c_id), .in_sel(c_is),
        .out_valid(c_ov), .out_ready(c_or), .out_data(c_od), .out_sel(c_os), .err_sel(c_es), .clr_err(c_ce));
    mux_sel_pipe #(.WIDTH(8), .NUM_IN(5)) u_d (
        .clk(clk), .rst(rst), .in_valid(d_iv), .in_ready(d_ir), .in_data(d_id), .in_sel(d_is),
        .out_valid(d_ov), .out_ready(d_or), .out_data(d_od), .out_sel(d_os), .err_sel(d_es), .clr_err(d_ce));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; a_iv = 1'b1; a_id = {5'h1A, 5'h03}; a_is = 1'b0; a_or = 1'b1;
        tick(); tick();
        nvec++; if (a_ir !== 1'b0) begin nmis++; $display("FAIL reset_in_ready got=%b exp=0", a_ir); end
        nvec++; if (a_ov !== 1'b0) begin nmis++; $display("FAIL reset_out_valid got=%b exp=0", a_ov); end
        nvec++; if (a_od !== 5'h00 || a_os !== 1'b0 || a_es !== 1'b0) begin
            nmis++; $display("FAIL reset_outputs got data=%h sel=%b err=%b exp 0/0/0", a_od, a_os, a_es); end
        rst = 1'b0;
        tick();
        nvec++; if (a_ir !== 1'b1) begin nmis++; $display("FAIL release_in_ready got=%b exp=1", a_ir); end
        nvec++; if (a_ov !== 1'b0) begin nmis++; $display("FAIL release_no_push got=%b exp=0", a_ov); end
        a_iv = 1'b0;
        tick();
    endtask

    task automatic test_select_2way();
        logic [4:0] lo, hi, exp;
        a_or = 1'b1; a_iv = 1'b1; a_id = {5'h1A, 5'h03}; a_is = 1'b0;
        tick();
        nvec++; if (a_ov !== 1'b1 || a_od !== 5'h03 || a_os !== 1'b0) begin
            nmis++; $display("FAIL sel0 got v=%b d=%h s=%b exp v=1 d=03 s=0", a_ov, a_od, a_os); end
        a_is = 1'b1;
        tick();
        nvec++; if (a_ov !== 1'b1 || a_od !== 5'h1A || a_os !== 1'b1) begin
            nmis++; $display("FAIL sel1 got v=%b d=%h s=%b exp v=1 d=1a s=1", a_ov, a_od, a_os); end
        for (int i = 0; i < 10; i++) begin
            lo = 5'(i * 5 + 2);
            hi = 5'(i * 3 + 17);
            exp = (i % 2 == 1) ? hi : lo;
            a_id = {hi, lo};
            a_is = 1'(i % 2);
            nvec++; if (a_ir !== 1'b1) begin nmis++; $display("FAIL b2b_ready beat=%0d got=%b exp=1", i, a_ir); end
            tick();
            nvec++; if (a_ov !== 1'b1 || a_od !== exp || a_os !== 1'(i % 2)) begin
                nmis++; $display("FAIL b2b_beat beat=%0d got v=%b d=%h s=%b exp d=%h s=%0d", i, a_ov, a_od, a_os, exp, i % 2); end
        end
        a_iv = 1'b0;
        tick();
        nvec++; if (a_ov !== 1'b0) begin nmis++; $display("FAIL b2b_drain got=%b exp=0", a_ov); end
    endtask

    task automatic test_skid_full();
        b_or = 1'b0; b_iv = 1'b1;
        b_id = {5'h04, 5'h13, 5'h0C, 5'h01}; b_is = 2'd2;
        tick();
        nvec++; if (b_ov !== 1'b1 || b_od !== 5'h13 || b_ir !== 1'b1) begin
            nmis++; $display("FAIL full_first got v=%b d=%h r=%b exp v=1 d=13 r=1", b_ov, b_od, b_ir); end
        b_id = {5'h1F, 5'h02, 5'h05, 5'h06}; b_is = 2'd3;
        tick();
        b_iv = 1'b0; b_id = '0;
        nvec++; if (b_ir !== 1'b0) begin nmis++; $display("FAIL full_ready got=%b exp=0", b_ir); end
        tick();
        nvec++; if (b_ov !== 1'b1 || b_od !== 5'h13 || b_os !== 2'd2) begin
            nmis++; $display("FAIL full_hold got v=%b d=%h s=%0d exp v=1 d=13 s=2", b_ov, b_od, b_os); end
        b_or = 1'b1;
        tick();
        nvec++; if (b_ov !== 1'b1 || b_od !== 5'h1F || b_os !== 2'd3) begin
            nmis++; $display("FAIL drain_second got v=%b d=%h s=%0d exp v=1 d=1f s=3", b_ov, b_od, b_os); end
        nvec++; if (b_ir !== 1'b1) begin nmis++; $display("FAIL drain_ready got=%b exp=1", b_ir); end
        tick();
        nvec++; if (b_ov !== 1'b0) begin nmis++; $display("FAIL drain_empty got=%b exp=0", b_ov); end
    endtask

    task automatic test_err_sel();
        c_or = 1'b1; c_iv = 1'b1; c_id = {5'h07, 5'h15, 5'h0A}; c_is = 2'd3;
        tick();
        nvec++; if (c_ov !== 1'b1 || c_od !== 5'h00 || c_os !== 2'd3 || c_es !== 1'b1) begin
            nmis++; $display("FAIL oor_push got v=%b d=%h s=%0d e=%b exp v=1 d=00 s=3 e=1", c_ov, c_od, c_os, c_es); end
        c_is = 2'd1;
        tick();
        c_iv = 1'b0;
        nvec++; if (c_od !== 5'h15 || c_es !== 1'b1) begin
            nmis++; $display("FAIL err_held got d=%h e=%b exp d=15 e=1", c_od, c_es); end
        c_ce = 1'b1;
        tick();
        c_ce = 1'b0;
        nvec++; if (c_es !== 1'b0) begin nmis++; $display("FAIL err_clear got=%b exp=0", c_es); end
        c_ce = 1'b1; c_iv = 1'b1; c_is = 2'd3;
        tick();
        c_ce = 1'b0; c_iv = 1'b0;
        nvec++; if (c_es !== 1'b1 || c_od !== 5'h00) begin
            nmis++; $display("FAIL err_set_wins got e=%b d=%h exp e=1 d=00", c_es, c_od); end
        tick();
    endtask

    task automatic test_reset_mid_stall();
        b_or = 1'b0; b_iv = 1'b1; b_id = {5'h11, 5'h12, 5'h13, 5'h14}; b_is = 2'd0;
        tick(); tick();
        b_iv = 1'b0;
        nvec++; if (b_ir !== 1'b0 || b_ov !== 1'b1) begin
            nmis++; $display("FAIL pre_rst_full got r=%b v=%b exp r=0 v=1", b_ir, b_ov); end
        #2 rst = 1'b1;
        #1;
        nvec++; if (b_ov !== 1'b0 || b_od !== 5'h00) begin
            nmis++; $display("FAIL async_rst got v=%b d=%h exp v=0 d=00", b_ov, b_od); end
        tick();
        rst = 1'b0;
        tick();
        b_iv = 1'b1; b_id = {5'h08, 5'h09, 5'h1E, 5'h0B}; b_is = 2'd1;
        tick();
        b_iv = 1'b0;
        nvec++; if (b_ov !== 1'b1 || b_od !== 5'h1E || b_os !== 2'd1) begin
            nmis++; $display("FAIL post_rst_beat got v=%b d=%h s=%0d exp v=1 d=1e s=1", b_ov, b_od, b_os); end
        b_or = 1'b1;
        tick();
        nvec++; if (b_ov !== 1'b0) begin nmis++; $display("FAIL no_stale got v=%b d=%h exp v=0", b_ov, b_od); end
    endtask

    task automatic test_random();
        logic [10:0] q[$];
        logic [10:0] head;
        logic [7:0]  word;
        logic [7:0]  hold_d;
        logic [2:0]  hold_s;
        logic        stall;
        int pushed = 0;
        int cyc = 0;
        while (pushed < 10000 && cyc < 80000) begin
            d_iv = ($urandom_range(0, 1) == 1);
            d_or = ($urandom_range(0, 1) == 1);
            d_is = 3'($urandom_range(0, 7));
            d_id = {$urandom, $urandom};
            if (d_iv && d_ir) begin
                word = (d_is < 3'd5) ? d_id[d_is*8 +: 8] : 8'h00;
                q.push_back({d_is, word});
                pushed++;
            end
            if (d_ov && d_or) begin
                nvec++;
                if (q.size() == 0) begin
                    nmis++; $display("FAIL rnd_extra got d=%h exp=none", d_od);
                end else begin
                    head = q.pop_front();
                    if ({d_os, d_od} !== head) begin
                        nmis++; $display("FAIL rnd_beat got s=%0d d=%h exp s=%0d d=%h", d_os, d_od, head[10:8], head[7:0]);
                    end
                end
            end
            stall = d_ov & ~d_or;
            hold_d = d_od;
            hold_s = d_os;
            tick();
            cyc++;
            if (stall) begin
                nvec++;
                if (d_ov !== 1'b1 || d_od !== hold_d || d_os !== hold_s) begin
                    nmis++; $display("FAIL rnd_stall got v=%b d=%h exp v=1 d=%h", d_ov, d_od, hold_d);
                end
            end
        end
        nvec++; if (pushed < 10000) begin nmis++; $display("FAIL rnd_budget got=%0d exp=10000", pushed); end
        d_iv = 1'b0; d_or = 1'b1;
        for (int i = 0; i < 4 && q.size() != 0; i++) begin
            if (d_ov) begin
                head = q.pop_front();
                nvec++;
                if ({d_os, d_od} !== head) begin
                    nmis++; $display("FAIL rnd_drain got s=%0d d=%h exp s=%0d d=%h", d_os, d_od, head[10:8], head[7:0]);
                end
            end
            tick();
        end
        nvec++; if (q.size() != 0 || d_ov !== 1'b0) begin
            nmis++; $display("FAIL rnd_final got left=%0d v=%b exp left=0 v=0", q.size(), d_ov); end
    endtask

    initial begin
        test_reset();
        test_select_2way();
        test_skid_full();
        test_err_sel();
        test_reset_mid_stall();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
